// File: rtl/ctx_queue_arbiter.sv
// ctx_queue_arbiter
//   Shares one thread-context queue between N_REQ shader cores. Pop requests
//   (fetch a context) and push requests (return a yielded context) are each
//   arbitrated round-robin with independent pointers. When both are eligible
//   in the same cycle the direction alternates. A read and a write are never
//   issued to the queue in the same cycle.
//
// Ports
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   pop_req         per-core pop request, held until pop_gnt
//   pop_gnt         one-hot combinational pop grant (q_reading same cycle)
//   pop_valid       one-hot registered: pop_data belongs to this core
//   pop_data        popped context, mirrors q_rdata
//   push_req        per-core push request, held until push_gnt
//   push_data       per-core context, core i at [i*DATA_W +: DATA_W]
//   push_gnt        one-hot combinational push grant (q_adding same cycle)
//   q_reading       dequeue strobe to the queue
//   q_adding        enqueue strobe to the queue
//   q_wdata         enqueue data (granted core's push_data slice)
//   q_rdata         dequeued data, valid the cycle after q_reading
//   q_size          queue occupancy
//   q_err           queue error flag
//   err             sticky copy of q_err, cleared only by rst
//
// Optional feature macro: CTX_ARB_STATS_EN
//   Adds stat_pops, stat_pushes, stat_stalls (32-bit saturating counters of
//   granted pops, granted pushes, and cycles with a request but no grant).

module ctx_queue_arbiter #(
  parameter int                N_REQ      = 4,
  parameter int                DATA_W     = 256,
  parameter int                SIZE_W     = 16,
  parameter logic [SIZE_W-1:0] FULL_LEVEL = SIZE_W'(16'hfffe)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        pop_req,
  output logic [N_REQ-1:0]        pop_gnt,
  output logic [N_REQ-1:0]        pop_valid,
  output logic [DATA_W-1:0]       pop_data,
  input  logic [N_REQ-1:0]        push_req,
  input  logic [N_REQ*DATA_W-1:0] push_data,
  output logic [N_REQ-1:0]        push_gnt,
  output logic                    q_reading,
  output logic                    q_adding,
  output logic [DATA_W-1:0]       q_wdata,
  input  logic [DATA_W-1:0]       q_rdata,
  input  logic [SIZE_W-1:0]       q_size,
  input  logic                    q_err,
  output logic                    err
`ifdef CTX_ARB_STATS_EN
  ,
  output logic [31:0]             stat_pops,
  output logic [31:0]             stat_pushes,
  output logic [31:0]             stat_stalls
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // First set request at or after ptr, wrapping. Scanning from the farthest
  // offset down lets the nearest requester overwrite earlier candidates.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] win;
    int               idx;
    win = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (req[idx]) win = PTR_W'(idx);
    end
    return win;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] win);
    return (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hffff_ffff) ? c : c + 32'd1;
  endfunction

  logic [PTR_W-1:0] pop_ptr, push_ptr;
  logic [PTR_W-1:0] pop_win, push_win;
  logic             favour_pop;
  logic             pop_ok, push_ok;
  logic             do_pop, do_push;
  logic [N_REQ-1:0] vld_p1;

  // ---- stage p0: eligibility, direction select and round-robin pick ----
  always_comb begin
    pop_ok   = (|pop_req) && (q_size != '0);
    push_ok  = (|push_req) && (q_size < FULL_LEVEL);
    pop_win  = rr_pick(pop_req, pop_ptr);
    push_win = rr_pick(push_req, push_ptr);
    // On a conflict favour_pop decides; otherwise the lone eligible side wins.
    do_pop   = !rst && pop_ok  && (favour_pop || !push_ok);
    do_push  = !rst && push_ok && (!favour_pop || !pop_ok);
  end

  assign pop_gnt   = do_pop  ? (N_REQ'(1) << pop_win)  : '0;
  assign push_gnt  = do_push ? (N_REQ'(1) << push_win) : '0;
  assign q_reading = do_pop;
  assign q_adding  = do_push;
  assign q_wdata   = push_data[int'(push_win)*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_ptr    <= '0;
      push_ptr   <= '0;
      favour_pop <= 1'b1;
      err        <= 1'b0;
    end else begin
      if (do_pop)  pop_ptr  <= ptr_next(pop_win);
      if (do_push) push_ptr <= ptr_next(push_win);
      if (pop_ok && push_ok) favour_pop <= !favour_pop;
      if (q_err) err <= 1'b1;
    end
  end

  // ---- stage p1: pop return, queue data arrives one cycle after the read ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= '0;
    else     vld_p1 <= pop_gnt;
  end

  assign pop_valid = vld_p1;
  assign pop_data  = q_rdata;

`ifdef CTX_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pops   <= '0;
      stat_pushes <= '0;
      stat_stalls <= '0;
    end else begin
      if (do_pop)  stat_pops   <= sat_inc(stat_pops);
      if (do_push) stat_pushes <= sat_inc(stat_pushes);
      if ((|pop_req || |push_req) && !(do_pop || do_push))
        stat_stalls <= sat_inc(stat_stalls);
    end
  end
`endif

endmodule

// File: tb/tb_ctx_queue_arbiter.sv
module tb_ctx_queue_arbiter;

  localparam int N = 4;
  localparam int W = 256;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   pop_req, pop_gnt, pop_valid, push_req, push_gnt;
  logic [W-1:0]   pop_data, q_wdata, q_rdata;
  logic [N*W-1:0] push_data;
  logic           q_reading, q_adding, q_err, err;
  logic [15:0]    q_size;
`ifdef CTX_ARB_STATS_EN
  logic [31:0]    stat_pops, stat_pushes, stat_stalls;
`endif

  ctx_queue_arbiter #(.N_REQ(N), .DATA_W(W), .SIZE_W(16), .FULL_LEVEL(16'hfffe)) dut (
    .clk(clk), .rst(rst),
    .pop_req(pop_req), .pop_gnt(pop_gnt), .pop_valid(pop_valid), .pop_data(pop_data),
    .push_req(push_req), .push_data(push_data), .push_gnt(push_gnt),
    .q_reading(q_reading), .q_adding(q_adding), .q_wdata(q_wdata),
    .q_rdata(q_rdata), .q_size(q_size), .q_err(q_err), .err(err)
`ifdef CTX_ARB_STATS_EN
    , .stat_pops(stat_pops), .stat_pushes(stat_pushes), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] pop_req;
    logic [N-1:0] push_req;
    logic [15:0]  q_size;
    logic [N-1:0] exp_pop_gnt;
    logic [N-1:0] exp_push_gnt;
    logic [W-1:0] exp_wdata;
  } vec_t;

  vec_t         tbl[$];
  logic [N-1:0] sb[$];
  int           total = 0;
  int           bad = 0;

  // Per-core push contexts; core 3 carries the 256'hA5 pattern.
  localparam logic [W-1:0] D0 = 256'h1111;
  localparam logic [W-1:0] D1 = 256'h2222;
  localparam logic [W-1:0] D2 = 256'h3333;
  localparam logic [W-1:0] D3 = 256'hA5;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [N-1:0] pr, input logic [N-1:0] ur, input logic [15:0] sz,
                     input logic [N-1:0] pg, input logic [N-1:0] ug, input logic [W-1:0] wd);
    vec_t v;
    v.pop_req = pr; v.push_req = ur; v.q_size = sz;
    v.exp_pop_gnt = pg; v.exp_push_gnt = ug; v.exp_wdata = wd;
    tbl.push_back(v);
  endtask

  // Advance to 1 time unit after the next rising edge, with fresh queue read data.
  task automatic step();
    @(posedge clk);
    #1;
    q_rdata = {8{$urandom}};
  endtask

  // pop_valid must match the grant predicted for the previous cycle.
  task automatic check_return();
    logic [N-1:0] e;
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk("pop_valid", pop_valid, e);
    if (e != '0) chk("pop_data", pop_data, q_rdata);
  endtask

  initial begin
    rst = 1'b1; pop_req = '0; push_req = '0; q_size = '0; q_err = 1'b0; q_rdata = '0;
    push_data = {D3, D2, D1, D0};

    // Reset state, with requests present while rst is high.
    #2;
    pop_req = 4'b1111; push_req = 4'b1111; q_size = 16'd8;
    #1;
    chk("rst_pop_gnt", pop_gnt, '0);
    chk("rst_push_gnt", push_gnt, '0);
    chk("rst_q_reading", q_reading, 1'b0);
    chk("rst_q_adding", q_adding, 1'b0);
    step();
    chk("rst_pop_valid", pop_valid, '0);
    chk("rst_err", err, 1'b0);
    pop_req = '0; push_req = '0;
    rst = 1'b0;

    // Reset mid-pop: two grants back to back, then rst before the second returns.
    step();
    q_size = 16'd8; pop_req = 4'b0001;
    #1;
    chk("mp_gnt0", pop_gnt, 4'b0001);
    step();
    chk("mp_valid0", pop_valid, 4'b0001);
    chk("mp_gnt1", pop_gnt, 4'b0001);
    rst = 1'b1;
    #1;
    chk("mp_valid_async", pop_valid, '0);
    chk("mp_gnt_rst", pop_gnt, '0);
    chk("mp_rd_rst", q_reading, 1'b0);
    step();
    chk("mp_valid_rst", pop_valid, '0);
    chk("mp_err_rst", err, 1'b0);
    pop_req = '0;
    rst = 1'b0;

    // Table: pointers 0, favour_pop=1 at start.
    add(4'b1111, 4'b0000, 16'd8,      4'b0001, 4'b0000, '0);
    add(4'b1111, 4'b0000, 16'd8,      4'b0010, 4'b0000, '0);
    add(4'b1111, 4'b0000, 16'd8,      4'b0100, 4'b0000, '0);
    add(4'b1111, 4'b0000, 16'd8,      4'b1000, 4'b0000, '0);
    add(4'b0000, 4'b0000, 16'd8,      4'b0000, 4'b0000, '0);
    add(4'b0010, 4'b0000, 16'd0,      4'b0000, 4'b0000, '0);
    add(4'b0010, 4'b1000, 16'd0,      4'b0000, 4'b1000, D3);
    add(4'b0010, 4'b0000, 16'd1,      4'b0010, 4'b0000, '0);
    add(4'b0001, 4'b0100, 16'd5,      4'b0001, 4'b0000, '0);
    add(4'b0001, 4'b0100, 16'd5,      4'b0000, 4'b0100, D2);
    add(4'b0001, 4'b0100, 16'd5,      4'b0001, 4'b0000, '0);
    add(4'b0001, 4'b0100, 16'd5,      4'b0000, 4'b0100, D2);
    add(4'b0000, 4'b0001, 16'hfffe,   4'b0000, 4'b0000, '0);
    add(4'b0010, 4'b0001, 16'hfffe,   4'b0010, 4'b0000, '0);
    add(4'b0000, 4'b0001, 16'hffff,   4'b0000, 4'b0000, '0);
    add(4'b0000, 4'b0001, 16'hfffd,   4'b0000, 4'b0001, D0);
    add(4'b0011, 4'b0000, 16'd3,      4'b0001, 4'b0000, '0);
    add(4'b0011, 4'b0000, 16'd3,      4'b0010, 4'b0000, '0);
    add(4'b0000, 4'b1111, 16'd3,      4'b0000, 4'b0010, D1);
    add(4'b1000, 4'b1010, 16'd3,      4'b1000, 4'b0000, '0);
    add(4'b1000, 4'b1010, 16'd3,      4'b0000, 4'b1000, D3);
    add(4'b0000, 4'b0000, 16'd0,      4'b0000, 4'b0000, '0);

    sb.delete();
    for (int k = 0; k < tbl.size(); k++) begin
      step();
      check_return();
      pop_req = tbl[k].pop_req; push_req = tbl[k].push_req; q_size = tbl[k].q_size;
      #2;
      chk($sformatf("pop_gnt[%0d]", k), pop_gnt, tbl[k].exp_pop_gnt);
      chk($sformatf("push_gnt[%0d]", k), push_gnt, tbl[k].exp_push_gnt);
      chk($sformatf("q_reading[%0d]", k), q_reading, |tbl[k].exp_pop_gnt);
      chk($sformatf("q_adding[%0d]", k), q_adding, |tbl[k].exp_push_gnt);
      if (tbl[k].exp_push_gnt != '0) chk($sformatf("q_wdata[%0d]", k), q_wdata, tbl[k].exp_wdata);
      sb.push_back(tbl[k].exp_pop_gnt);
    end
    step();
    check_return();
    pop_req = '0; push_req = '0;

    // Sticky error: one-cycle q_err pulse.
    q_err = 1'b1;
    step();
    q_err = 1'b0;
    chk("err_set", err, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("err_hold", err, 1'b1);
    end
    rst = 1'b1;
    #1;
    chk("err_clr", err, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("err_after_rst", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
